// File: rtl/wb_led_pwm.sv
// Wishbone (pipelined, 32-bit) LED controller: per-channel off/on/PWM/blink modes,
// shared prescaler tick and PWM counter, configurable output polarity.
module wb_led_pwm #(
  parameter int unsigned NUM_LEDS   = 6,
  parameter int unsigned PWM_BITS   = 8,
  parameter bit          RST_INVERT = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  output logic [NUM_LEDS-1:0] o_leds,
  input  logic [31:0]         i_wb_addr,
  input  logic [31:0]         i_wb_data,
  input  logic [3:0]          i_wb_sel,
  input  logic                i_wb_we,
  input  logic                i_wb_cyc,
  input  logic                i_wb_stb,
  output logic                o_wb_ack,
  output logic [31:0]         o_wb_data,
  output logic                o_wb_stall,
  output logic                o_wb_err
);

  logic                en_q, inv_q;
  logic [15:0]         presc_q, pre_cnt_q;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PWM_BITS-1:0] duty_q      [NUM_LEDS];
  logic [1:0]          mode_q      [NUM_LEDS];
  logic [7:0]          half_q      [NUM_LEDS];
  logic [7:0]          blink_cnt_q [NUM_LEDS];
  logic [NUM_LEDS-1:0] blink_q, lvl_q, lvl_d, leds_q, ch_wr;
  logic                ack_q, err_q;
  logic [31:0]         rdata_q, rdata_d;
  logic [15:0]         wmask;
  logic [3:0]          ch_idx;
  logic                valid, wr, tick, mapped;
  logic                sel_ctrl, sel_pre, sel_stat, sel_ch;
  logic                unused_bits;

  assign valid    = i_wb_cyc & i_wb_stb;
  assign ch_idx   = i_wb_addr[5:2];
  // Offsets 0x80 and above within the local window are unmapped.
  assign sel_ctrl = (i_wb_addr[7:2] == 6'd0);
  assign sel_pre  = (i_wb_addr[7:2] == 6'd1);
  assign sel_stat = (i_wb_addr[7:2] == 6'd2);
  assign sel_ch   = (i_wb_addr[7:6] == 2'b01) && (32'(ch_idx) < NUM_LEDS);
  assign mapped   = sel_ctrl | sel_pre | sel_stat | sel_ch;
  assign wr       = valid & i_wb_we & mapped;
  assign wmask    = {{8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
  assign tick     = en_q & (pre_cnt_q == presc_q);

  always_comb begin
    ch_wr = '0;
    for (int n = 0; n < NUM_LEDS; n++) begin
      ch_wr[n] = wr & sel_ch & (ch_idx == 4'(n));
    end
  end

  always_comb begin
    lvl_d = '0;
    for (int n = 0; n < NUM_LEDS; n++) begin
      case (mode_q[n])
        2'd0: lvl_d[n] = 1'b0;
        2'd1: lvl_d[n] = 1'b1;
        2'd2: lvl_d[n] = (pwm_cnt_q < duty_q[n]);
        2'd3: lvl_d[n] = blink_q[n];
      endcase
    end
    if (!en_q) lvl_d = '0;
  end

  always_comb begin
    rdata_d = '0;
    if (sel_ctrl) rdata_d[1:0] = {inv_q, en_q};
    if (sel_pre)  rdata_d[15:0] = presc_q;
    if (sel_stat) rdata_d[NUM_LEDS-1:0] = lvl_q;
    for (int n = 0; n < NUM_LEDS; n++) begin
      if (sel_ch && (ch_idx == 4'(n))) begin
        rdata_d[PWM_BITS-1:0] = duty_q[n];
        rdata_d[17:16]        = mode_q[n];
        rdata_d[31:24]        = half_q[n];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      en_q      <= 1'b1;
      inv_q     <= RST_INVERT;
      presc_q   <= '0;
      pre_cnt_q <= '0;
      pwm_cnt_q <= '0;
      blink_q   <= '0;
      lvl_q     <= '0;
      leds_q    <= {NUM_LEDS{RST_INVERT}};
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      for (int n = 0; n < NUM_LEDS; n++) begin
        duty_q[n]      <= '0;
        mode_q[n]      <= '0;
        half_q[n]      <= '0;
        blink_cnt_q[n] <= '0;
      end
    end else begin
      ack_q   <= valid & mapped;
      err_q   <= valid & ~mapped;
      rdata_q <= (valid && mapped && !i_wb_we) ? rdata_d : '0;

      if (wr && sel_ctrl && i_wb_sel[0]) begin
        en_q  <= i_wb_data[0];
        inv_q <= i_wb_data[1];
      end

      // A PRESCALE write restarts the tick phase, even on a tick cycle.
      if (wr && sel_pre) begin
        if (i_wb_sel[0]) presc_q[7:0]  <= i_wb_data[7:0];
        if (i_wb_sel[1]) presc_q[15:8] <= i_wb_data[15:8];
        pre_cnt_q <= '0;
      end else if (tick) begin
        pre_cnt_q <= '0;
      end else if (en_q) begin
        pre_cnt_q <= pre_cnt_q + 16'd1;
      end

      if (tick) pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);

      for (int n = 0; n < NUM_LEDS; n++) begin
        if (ch_wr[n]) begin
          duty_q[n] <= (duty_q[n] & ~wmask[PWM_BITS-1:0]) |
                       (i_wb_data[PWM_BITS-1:0] & wmask[PWM_BITS-1:0]);
          if (i_wb_sel[2]) mode_q[n] <= i_wb_data[17:16];
          if (i_wb_sel[3]) half_q[n] <= i_wb_data[31:24];
        end
        if (ch_wr[n] && i_wb_sel[2]) begin
          blink_cnt_q[n] <= '0;
          blink_q[n]     <= 1'b0;
        end else if (tick) begin
          if (blink_cnt_q[n] == half_q[n]) begin
            blink_cnt_q[n] <= '0;
            blink_q[n]     <= ~blink_q[n];
          end else begin
            blink_cnt_q[n] <= blink_cnt_q[n] + 8'd1;
          end
        end
      end

      lvl_q  <= lvl_d;
      leds_q <= lvl_d ^ {NUM_LEDS{inv_q}};
    end
  end

  assign o_leds     = leds_q;
  assign o_wb_ack   = ack_q & i_wb_cyc;
  assign o_wb_err   = err_q & i_wb_cyc;
  assign o_wb_data  = rdata_q;
  assign o_wb_stall = 1'b0;

  assign unused_bits = ^{i_wb_addr[31:8], i_wb_addr[1:0], i_wb_data, wmask};

endmodule
